// File: rtl/simon_core.sv
// Simon memory game core: LFSR-generated colour sequence, lamp playback, key echo and scoring.
// Optional input-wait timeout is compiled in with `define SIMON_TIMEOUT_EN.
module simon_core #(
  parameter  int NUM_COLORS     = 4,
  parameter  int MAX_LEN        = 256,
  parameter  int SHOW_CYCLES    = 25000000,
  parameter  int GAP_CYCLES     = 12500000,
  parameter  int TIMEOUT_CYCLES = 250000000,
  localparam int CW             = (NUM_COLORS > 2) ? $clog2(NUM_COLORS) : 1,
  localparam int LW             = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  key_valid,
  input  logic [CW-1:0]         key_idx,
  output logic [NUM_COLORS-1:0] lamp,
  output logic [LW-1:0]         level,
  output logic [LW-1:0]         max_score,
  output logic                  showing,
  output logic                  ready_in,
  output logic                  game_over,
  output logic                  game_won
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_GAP,
    WAIT_IN,
    PAUSE,
    LOSE,
    WIN
  } state_t;

  if (NUM_COLORS < 2 || NUM_COLORS > 16 || MAX_LEN < 2 || MAX_LEN > 1024 ||
      SHOW_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("simon_core: parameter out of range");
  end

  state_t                  state_q, state_d;
  logic [LW-1:0]           level_q, level_d;
  logic [LW-1:0]           idx_q, idx_d;
  logic [LW-1:0]           max_q, max_d;
  logic [31:0]             timer_q, timer_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [NUM_COLORS-1:0]   lamp_q, lamp_d;
  logic                    showing_q, showing_d;
  logic                    ready_q, ready_d;
  logic                    over_q, over_d;
  logic                    won_q, won_d;

  logic [CW-1:0]           store_q [MAX_LEN];
  logic                    store_we;
  logic [LW-1:0]           rd_addr;
  logic [CW-1:0]           rd_color;
  logic [CW-1:0]           new_color;
  logic [CW-1:0]           show_color;
  logic                    key_ok;

  function automatic logic [NUM_COLORS-1:0] onehot(input logic [CW-1:0] c);
    onehot = NUM_COLORS'(1) << c;
  endfunction

  function automatic logic [LW-1:0] best(input logic [LW-1:0] cur, input logic [LW-1:0] lvl);
    best = ((lvl - LW'(1)) > cur) ? (lvl - LW'(1)) : cur;
  endfunction

  // Codes beyond the last colour can only occur when NUM_COLORS is not a power of two.
  if (NUM_COLORS == (1 << CW)) begin : g_full_keys
    assign key_ok = 1'b1;
  end else begin : g_part_keys
    assign key_ok = (key_idx < CW'(NUM_COLORS));
  end

  assign new_color = CW'(lfsr_q % 16'(NUM_COLORS));
  assign rd_color  = store_q[rd_addr[AW-1:0]];

  // The first colour of a game is being written in ADD, so playback must bypass the store.
  assign show_color = (state_q == ADD && level_q == '0) ? new_color : rd_color;

  always_ff @(posedge clk) begin
    if (store_we) begin
      store_q[level_q[AW-1:0]] <= new_color;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    idx_d    = idx_q;
    max_d    = max_q;
    timer_d  = timer_q;
    store_we = 1'b0;
    rd_addr  = idx_q;
    lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    case (state_q)
      IDLE, LOSE, WIN: begin
        if (start) begin
          level_d = '0;
          idx_d   = '0;
          timer_d = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        store_we = 1'b1;
        level_d  = level_q + LW'(1);
        idx_d    = '0;
        rd_addr  = '0;
        timer_d  = '0;
        state_d  = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer_q == 32'(SHOW_CYCLES - 1)) begin
          timer_d = '0;
          state_d = SHOW_GAP;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      SHOW_GAP: begin
        if (timer_q == 32'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          if (idx_q + LW'(1) == level_q) begin
            idx_d   = '0;
            state_d = WAIT_IN;
          end else begin
            idx_d   = idx_q + LW'(1);
            rd_addr = idx_q + LW'(1);
            state_d = SHOW_ON;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      WAIT_IN: begin
        if (key_valid && key_ok) begin
          if (key_idx == rd_color) begin
            idx_d   = idx_q + LW'(1);
            timer_d = '0;
            if (idx_q + LW'(1) == level_q) begin
              if (level_q == LW'(MAX_LEN)) begin
                max_d   = LW'(MAX_LEN);
                state_d = WIN;
              end else begin
                state_d = PAUSE;
              end
            end
          end else begin
            max_d   = best(max_q, level_q);
            state_d = LOSE;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
          max_d   = best(max_q, level_q);
          timer_d = '0;
          state_d = LOSE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
`endif
      end
      PAUSE: begin
        if (timer_q == 32'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          state_d = ADD;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the registered state.
    lamp_d    = '0;
    showing_d = 1'b0;
    ready_d   = 1'b0;
    over_d    = 1'b0;
    won_d     = 1'b0;
    case (state_d)
      SHOW_ON: begin
        lamp_d    = onehot(show_color);
        showing_d = 1'b1;
      end
      SHOW_GAP: showing_d = 1'b1;
      WAIT_IN:  ready_d   = 1'b1;
      LOSE: begin
        lamp_d = onehot(rd_color);
        over_d = 1'b1;
      end
      WIN: begin
        lamp_d = '1;
        won_d  = 1'b1;
      end
      default: lamp_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      level_q   <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      timer_q   <= '0;
      lfsr_q    <= 16'hACE1;
      lamp_q    <= '0;
      showing_q <= 1'b0;
      ready_q   <= 1'b0;
      over_q    <= 1'b0;
      won_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      timer_q   <= timer_d;
      lfsr_q    <= lfsr_d;
      lamp_q    <= lamp_d;
      showing_q <= showing_d;
      ready_q   <= ready_d;
      over_q    <= over_d;
      won_q     <= won_d;
    end
  end

  assign lamp      = lamp_q;
  assign level     = level_q;
  assign max_score = max_q;
  assign showing   = showing_q;
  assign ready_in  = ready_q;
  assign game_over = over_q;
  assign game_won  = won_q;

endmodule

// File: tb/tb_simon_core.sv
// Self-checking bench for simon_core: directed games against a reference LFSR model,
// plus a NUM_COLORS=3 instance for out-of-range key handling.
module tb_simon_core;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int MAXL = 3;
  localparam int TOUT = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, key_valid;
  logic [1:0] key_idx;
  logic [3:0] lamp;
  logic [1:0] level, max_score;
  logic       showing, ready_in, game_over, game_won;

  logic       start3, key_valid3;
  logic [1:0] key_idx3;
  logic [2:0] lamp3;
  logic [1:0] level3, max_score3;
  logic       showing3, ready_in3, game_over3, game_won3;

  simon_core #(
    .NUM_COLORS(4), .MAX_LEN(MAXL), .SHOW_CYCLES(SHOW),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .key_valid(key_valid),
    .key_idx(key_idx), .lamp(lamp), .level(level), .max_score(max_score),
    .showing(showing), .ready_in(ready_in), .game_over(game_over), .game_won(game_won)
  );

  simon_core #(
    .NUM_COLORS(3), .MAX_LEN(MAXL), .SHOW_CYCLES(SHOW),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT)
  ) dut3 (
    .clk(clk), .reset(reset), .start(start3), .key_valid(key_valid3),
    .key_idx(key_idx3), .lamp(lamp3), .level(level3), .max_score(max_score3),
    .showing(showing3), .ready_in(ready_in3), .game_over(game_over3), .game_won(game_won3)
  );

  always #5 clk = ~clk;

  // Reference Galois LFSR, taps 16,14,13,11, free-running like the design's.
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
  end

  typedef struct {
    int pos;
    bit wrong;
    bit exp_ready;
    bit exp_over;
    bit exp_won;
    bit round_end;
  } press_t;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] seq [MAXL];
  int         lvl_m;
  logic [1:0] c3;
  logic [3:0] oh;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at the falling edge inside the one-clock ADD state.
  task automatic add_round();
    checkOutput("add_lamp_dark", 32'(lamp), 32'd0);
    checkOutput("add_not_showing", 32'(showing), 32'd0);
    seq[lvl_m] = 2'(lfsr_m % 16'd4);
    lvl_m++;
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lvl_m = 0;
    checkOutput("add_level_cleared", 32'(level), 32'd0);
    add_round();
  endtask

  task automatic play_back(input bit inject);
    for (int i = 0; i < lvl_m; i++) begin
      oh = 4'b0001 << seq[i];
      for (int c = 0; c < SHOW; c++) begin
        @(negedge clk);
        checkOutput("show_lamp", 32'(lamp), 32'(oh));
        checkOutput("show_flag", 32'(showing), 32'd1);
        if (inject && i == 0 && c == 1) begin
          key_valid = 1'b1;
          key_idx   = seq[0];
        end else begin
          key_valid = 1'b0;
        end
      end
      for (int g = 0; g < GAP; g++) begin
        @(negedge clk);
        key_valid = 1'b0;
        checkOutput("gap_lamp_dark", 32'(lamp), 32'd0);
        checkOutput("gap_flag", 32'(showing), 32'd1);
      end
    end
    @(negedge clk);
    checkOutput("wait_ready_in", 32'(ready_in), 32'd1);
    checkOutput("wait_lamp_dark", 32'(lamp), 32'd0);
    checkOutput("wait_level", 32'(level), 32'(lvl_m));
  endtask

  task automatic applyStimulus(input press_t v);
    key_valid = 1'b1;
    key_idx   = v.wrong ? 2'(seq[v.pos] + 2'd1) : seq[v.pos];
    @(negedge clk);
    key_valid = 1'b0;
    checkOutput("press_ready_in", 32'(ready_in), 32'(v.exp_ready));
    checkOutput("press_game_over", 32'(game_over), 32'(v.exp_over));
    checkOutput("press_game_won", 32'(game_won), 32'(v.exp_won));
  endtask

  task automatic pause_then_add();
    checkOutput("pause_lamp_dark", 32'(lamp), 32'd0);
    @(negedge clk);
    checkOutput("pause_not_ready", 32'(ready_in), 32'd0);
    @(negedge clk);
    add_round();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  press_t win_tab [6];

  initial begin
    win_tab[0] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    win_tab[1] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    win_tab[2] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    win_tab[3] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    win_tab[4] = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    win_tab[5] = '{2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; start = 1'b0; key_valid = 1'b0; key_idx = 2'd0;
    start3 = 1'b0; key_valid3 = 1'b0; key_idx3 = 2'd0;
    lvl_m = 0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_lamp", 32'(lamp), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_max_score", 32'(max_score), 32'd0);
    checkOutput("rst_flags", 32'({showing, ready_in, game_over, game_won}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Three-colour instance: key code 3 is not a colour and must be ignored.
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    c3 = 2'(lfsr_m % 16'd3);
    @(negedge clk);
    checkOutput("nc3_show_lamp", 32'(lamp3), 32'(3'b001 << c3));
    repeat (SHOW - 1 + GAP + 1) @(negedge clk);
    checkOutput("nc3_ready_in", 32'(ready_in3), 32'd1);
    key_valid3 = 1'b1; key_idx3 = 2'd3;
    @(negedge clk);
    key_valid3 = 1'b0;
    checkOutput("nc3_bad_key_ready", 32'(ready_in3), 32'd1);
    checkOutput("nc3_bad_key_over", 32'(game_over3), 32'd0);
    key_valid3 = 1'b1; key_idx3 = c3;
    @(negedge clk);
    key_valid3 = 1'b0;
    checkOutput("nc3_good_key_pause", 32'(ready_in3), 32'd0);
    checkOutput("nc3_good_key_over", 32'(game_over3), 32'd0);

    // Game 1: echo every round to a win.
    start_game();
    play_back(1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(win_tab[i]);
      if (win_tab[i].round_end && !win_tab[i].exp_won) begin
        pause_then_add();
        play_back(1'b0);
      end
    end
    checkOutput("win_lamp_all", 32'(lamp), 32'hF);
    checkOutput("win_max_score", 32'(max_score), 32'd3);
    checkOutput("win_level", 32'(level), 32'd3);

    // Game 2 from reset: key during playback ignored, then lose in round 2.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst2_max_score", 32'(max_score), 32'd0);
    checkOutput("rst2_won_cleared", 32'(game_won), 32'd0);
    @(negedge clk);
    start_game();
    play_back(1'b1);
    applyStimulus('{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    pause_then_add();
    play_back(1'b0);
`ifdef SIMON_TIMEOUT_EN
    repeat (TOUT - 1) @(negedge clk);
    checkOutput("tout_still_waiting", 32'(ready_in), 32'd1);
    @(negedge clk);
    checkOutput("tout_game_over", 32'(game_over), 32'd1);
`else
    repeat (1000) @(negedge clk);
    checkOutput("no_tout_waiting", 32'(ready_in), 32'd1);
    applyStimulus('{0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
`endif
    oh = 4'b0001 << seq[0];
    checkOutput("lose_max_score", 32'(max_score), 32'd1);
    checkOutput("lose_lamp_expected", 32'(lamp), 32'(oh));
    @(negedge clk);
    checkOutput("lose_holds", 32'(game_over), 32'd1);
    start_game();
    checkOutput("restart_over_cleared", 32'(game_over), 32'd0);
    play_back(1'b0);
    checkOutput("restart_max_kept", 32'(max_score), 32'd1);

    // Game 3: reset in the middle of round-2 playback.
    applyStimulus('{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    pause_then_add();
    @(negedge clk);
    oh = 4'b0001 << seq[0];
    checkOutput("pre_reset_show", 32'(lamp), 32'(oh));
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_lamp", 32'(lamp), 32'd0);
    checkOutput("mid_rst_level", 32'(level), 32'd0);
    checkOutput("mid_rst_max", 32'(max_score), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_lamp", 32'(lamp), 32'd0);
    checkOutput("idle_flags", 32'({showing, ready_in, game_over, game_won}), 32'd0);
    checkOutput("idle_level", 32'(level), 32'd0);
    checkOutput("idle_max", 32'(max_score), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
